// File: rtl/rs_param.sv
// rtl/rs_param.sv - parametrised ALU reservation station, N_CDB wakeup with dispatch bypass, oldest-ready issue
// Ages form a dense ranking (0 = youngest) so the oldest valid entry always has age rs_count-1.
module rs_param #(
   parameter int DEPTH  = 16,
   parameter int ROB_W  = 5,
   parameter int DATA_W = 32,
   parameter int OP_W   = 6,
   parameter int N_CDB  = 2,
   localparam int AGE_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    rdy_in,
   input  logic                    flush_in,
   input  logic                    disp_valid,
   input  logic [OP_W-1:0]         disp_op,
   input  logic                    disp_q1_pend,
   input  logic [ROB_W-1:0]        disp_q1_tag,
   input  logic [DATA_W-1:0]       disp_v1,
   input  logic                    disp_q2_pend,
   input  logic [ROB_W-1:0]        disp_q2_tag,
   input  logic [DATA_W-1:0]       disp_v2,
   input  logic [DATA_W-1:0]       disp_imm,
   input  logic [DATA_W-1:0]       disp_pc,
   input  logic [ROB_W-1:0]        disp_rob_tag,
   input  logic [N_CDB-1:0]        cdb_valid,
   input  logic [N_CDB*ROB_W-1:0]  cdb_tag,
   input  logic [N_CDB*DATA_W-1:0] cdb_data,
   output logic                    rs_full,
   output logic [CNT_W-1:0]        rs_count,
   output logic                    alu_valid,
   input  logic                    alu_ready,
   output logic [OP_W-1:0]         alu_op,
   output logic [DATA_W-1:0]       alu_v1,
   output logic [DATA_W-1:0]       alu_v2,
   output logic [DATA_W-1:0]       alu_imm,
   output logic [DATA_W-1:0]       alu_pc,
   output logic [ROB_W-1:0]        alu_rob_tag
);

   logic [DEPTH-1:0]  e_vld, e_p1, e_p2;
   logic [OP_W-1:0]   e_op  [DEPTH];
   logic [ROB_W-1:0]  e_t1  [DEPTH];
   logic [ROB_W-1:0]  e_t2  [DEPTH];
   logic [ROB_W-1:0]  e_rob [DEPTH];
   logic [DATA_W-1:0] e_v1  [DEPTH];
   logic [DATA_W-1:0] e_v2  [DEPTH];
   logic [DATA_W-1:0] e_imm [DEPTH];
   logic [DATA_W-1:0] e_pc  [DEPTH];
   logic [AGE_W-1:0]  e_age [DEPTH];

   logic [CNT_W-1:0]  count;
   logic [AGE_W-1:0]  free_idx, sel_idx, sel_age;
   logic              any_rdy, disp_acc, slot_free, do_issue;
   logic              d_p1, d_p2;
   logic [DATA_W-1:0] d_v1, d_v2;

   assign rs_count  = count;
   assign rs_full   = (count == CNT_W'(DEPTH));
   assign disp_acc  = disp_valid && !rs_full;
   assign slot_free = !alu_valid || alu_ready;
   assign do_issue  = slot_free && any_rdy;

   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!e_vld[i]) free_idx = AGE_W'(i);
      any_rdy = 1'b0;
      sel_idx = '0;
      sel_age = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (e_vld[i] && !e_p1[i] && !e_p2[i] && (!any_rdy || e_age[i] > sel_age)) begin
            any_rdy = 1'b1;
            sel_idx = AGE_W'(i);
            sel_age = e_age[i];
         end
      end
   end

   // Descending scan so the lowest matching channel is the last (winning) assignment.
   always_comb begin
      d_p1 = disp_q1_pend;
      d_v1 = disp_v1;
      d_p2 = disp_q2_pend;
      d_v2 = disp_v2;
      for (int c = N_CDB - 1; c >= 0; c--) begin
         if (disp_q1_pend && cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == disp_q1_tag) begin
            d_p1 = 1'b0;
            d_v1 = cdb_data[c*DATA_W +: DATA_W];
         end
         if (disp_q2_pend && cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == disp_q2_tag) begin
            d_p2 = 1'b0;
            d_v2 = cdb_data[c*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         e_vld       <= '0;
         e_p1        <= '0;
         e_p2        <= '0;
         count       <= '0;
         alu_valid   <= 1'b0;
         alu_op      <= '0;
         alu_v1      <= '0;
         alu_v2      <= '0;
         alu_imm     <= '0;
         alu_pc      <= '0;
         alu_rob_tag <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            e_op[i]  <= '0;
            e_t1[i]  <= '0;
            e_t2[i]  <= '0;
            e_rob[i] <= '0;
            e_v1[i]  <= '0;
            e_v2[i]  <= '0;
            e_imm[i] <= '0;
            e_pc[i]  <= '0;
            e_age[i] <= '0;
         end
      end else if (rdy_in) begin
         if (flush_in) begin
            e_vld     <= '0;
            count     <= '0;
            alu_valid <= 1'b0;
         end else begin
            count <= count + CNT_W'(disp_acc) - CNT_W'(do_issue);
            for (int i = 0; i < DEPTH; i++) begin
               // Entries older than the one leaving close the gap to keep ages dense.
               if (e_vld[i])
                  e_age[i] <= e_age[i] + AGE_W'(disp_acc) - AGE_W'(do_issue && (e_age[i] > sel_age));
               for (int c = N_CDB - 1; c >= 0; c--) begin
                  if (e_vld[i] && e_p1[i] && cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == e_t1[i]) begin
                     e_p1[i] <= 1'b0;
                     e_v1[i] <= cdb_data[c*DATA_W +: DATA_W];
                  end
                  if (e_vld[i] && e_p2[i] && cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == e_t2[i]) begin
                     e_p2[i] <= 1'b0;
                     e_v2[i] <= cdb_data[c*DATA_W +: DATA_W];
                  end
               end
            end
            if (do_issue) begin
               e_vld[sel_idx] <= 1'b0;
               alu_valid      <= 1'b1;
               alu_op         <= e_op[sel_idx];
               alu_v1         <= e_v1[sel_idx];
               alu_v2         <= e_v2[sel_idx];
               alu_imm        <= e_imm[sel_idx];
               alu_pc         <= e_pc[sel_idx];
               alu_rob_tag    <= e_rob[sel_idx];
            end else if (slot_free) begin
               alu_valid <= 1'b0;
            end
            if (disp_acc) begin
               e_vld[free_idx] <= 1'b1;
               e_age[free_idx] <= '0;
               e_op[free_idx]  <= disp_op;
               e_p1[free_idx]  <= d_p1;
               e_t1[free_idx]  <= disp_q1_tag;
               e_v1[free_idx]  <= d_v1;
               e_p2[free_idx]  <= d_p2;
               e_t2[free_idx]  <= disp_q2_tag;
               e_v2[free_idx]  <= d_v2;
               e_imm[free_idx] <= disp_imm;
               e_pc[free_idx]  <= disp_pc;
               e_rob[free_idx] <= disp_rob_tag;
            end
         end
      end
   end

endmodule

// File: tb/tb_rs_param.sv
// tb/tb_rs_param.sv - self-checking bench for rs_param: queue-ordered model plus directed literal checks
module tb_rs_param;
   localparam int DEPTH = 16, ROB_W = 5, DATA_W = 32, OP_W = 6, N_CDB = 2;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
   logic disp_valid = 1'b0;
   logic [OP_W-1:0] disp_op = '0;
   logic disp_q1_pend = 1'b0, disp_q2_pend = 1'b0;
   logic [ROB_W-1:0] disp_q1_tag = '0, disp_q2_tag = '0, disp_rob_tag = '0;
   logic [DATA_W-1:0] disp_v1 = '0, disp_v2 = '0, disp_imm = '0, disp_pc = '0;
   logic [N_CDB-1:0] cdb_valid = '0;
   logic [N_CDB*ROB_W-1:0] cdb_tag = '0;
   logic [N_CDB*DATA_W-1:0] cdb_data = '0;
   logic rs_full, alu_valid, alu_ready = 1'b1;
   logic [CNT_W-1:0] rs_count;
   logic [OP_W-1:0] alu_op;
   logic [DATA_W-1:0] alu_v1, alu_v2, alu_imm, alu_pc;
   logic [ROB_W-1:0] alu_rob_tag;

   int n_chk = 0, n_pass = 0;

   rs_param #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W), .OP_W(OP_W), .N_CDB(N_CDB)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
      .disp_valid(disp_valid), .disp_op(disp_op),
      .disp_q1_pend(disp_q1_pend), .disp_q1_tag(disp_q1_tag), .disp_v1(disp_v1),
      .disp_q2_pend(disp_q2_pend), .disp_q2_tag(disp_q2_tag), .disp_v2(disp_v2),
      .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob_tag(disp_rob_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rs_full(rs_full), .rs_count(rs_count), .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_imm(alu_imm),
      .alu_pc(alu_pc), .alu_rob_tag(alu_rob_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Model: entries kept in dispatch order, so the oldest ready one is simply the first ready.
   typedef struct {
      logic [OP_W-1:0]   op;
      logic              p1;
      logic [ROB_W-1:0]  t1;
      logic [DATA_W-1:0] v1;
      logic              p2;
      logic [ROB_W-1:0]  t2;
      logic [DATA_W-1:0] v2;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      logic [ROB_W-1:0]  rob;
   } ent_t;

   ent_t mq[$];
   ent_t m_alu;
   logic m_av = 1'b0;

   function automatic logic [DATA_W:0] wake(input logic p, input logic [ROB_W-1:0] t,
                                            input logic [DATA_W-1:0] v);
      for (int c = 0; c < N_CDB; c++)
         if (p && cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == t)
            return {1'b0, cdb_data[c*DATA_W +: DATA_W]};
      return {p, v};
   endfunction

   function automatic void model_step();
      ent_t e;
      int sel;
      logic full;
      logic [DATA_W:0] w;
      if (!rdy) return;
      if (flush) begin
         mq.delete();
         m_av = 1'b0;
         return;
      end
      full = (mq.size() == DEPTH);
      if (!m_av || alu_ready) begin
         sel = -1;
         foreach (mq[k]) if (sel < 0 && !mq[k].p1 && !mq[k].p2) sel = k;
         if (sel >= 0) begin
            m_alu = mq[sel];
            m_av = 1'b1;
            mq.delete(sel);
         end else begin
            m_av = 1'b0;
         end
      end
      foreach (mq[k]) begin
         w = wake(mq[k].p1, mq[k].t1, mq[k].v1);
         mq[k].p1 = w[DATA_W];
         mq[k].v1 = w[DATA_W-1:0];
         w = wake(mq[k].p2, mq[k].t2, mq[k].v2);
         mq[k].p2 = w[DATA_W];
         mq[k].v2 = w[DATA_W-1:0];
      end
      if (disp_valid && !full) begin
         w = wake(disp_q1_pend, disp_q1_tag, disp_v1);
         e.p1 = w[DATA_W];
         e.v1 = w[DATA_W-1:0];
         w = wake(disp_q2_pend, disp_q2_tag, disp_v2);
         e.p2 = w[DATA_W];
         e.v2 = w[DATA_W-1:0];
         e.op = disp_op;
         e.t1 = disp_q1_tag;
         e.t2 = disp_q2_tag;
         e.imm = disp_imm;
         e.pc = disp_pc;
         e.rob = disp_rob_tag;
         mq.push_back(e);
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_av = 1'b0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_count", 64'(rs_count), 64'(mq.size()));
         chk("m_full", 64'(rs_full), 64'(mq.size() == DEPTH));
         chk("m_alu_valid", 64'(alu_valid), 64'(m_av));
         if (m_av) begin
            chk("m_alu_op", 64'(alu_op), 64'(m_alu.op));
            chk("m_alu_v1", 64'(alu_v1), 64'(m_alu.v1));
            chk("m_alu_v2", 64'(alu_v2), 64'(m_alu.v2));
            chk("m_alu_imm", 64'(alu_imm), 64'(m_alu.imm));
            chk("m_alu_pc", 64'(alu_pc), 64'(m_alu.pc));
            chk("m_alu_rob", 64'(alu_rob_tag), 64'(m_alu.rob));
         end
      end
   end

   task automatic idle();
      disp_valid = 1'b0;
      disp_q1_pend = 1'b0;
      disp_q2_pend = 1'b0;
      cdb_valid = '0;
      flush = 1'b0;
   endtask

   task automatic disp(input int op, input int p1, input int t1, input int v1,
                       input int p2, input int t2, input int v2, input int rob);
      disp_valid = 1'b1;
      disp_op = OP_W'(op);
      disp_q1_pend = (p1 != 0);
      disp_q1_tag = ROB_W'(t1);
      disp_v1 = DATA_W'(v1);
      disp_q2_pend = (p2 != 0);
      disp_q2_tag = ROB_W'(t2);
      disp_v2 = DATA_W'(v2);
      disp_imm = DATA_W'(rob * 4 + 1);
      disp_pc = DATA_W'(32'h1000 + rob * 4);
      disp_rob_tag = ROB_W'(rob);
   endtask

   task automatic cdb(input int ch, input int tag, input int data);
      cdb_valid[ch] = 1'b1;
      cdb_tag[ch*ROB_W +: ROB_W] = ROB_W'(tag);
      cdb_data[ch*DATA_W +: DATA_W] = DATA_W'(data);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      idle();
      repeat (2) @(negedge clk);
      chk("rst_count", 64'(rs_count), 64'd0);
      chk("rst_full", 64'(rs_full), 64'd0);
      chk("rst_alu_valid", 64'(alu_valid), 64'd0);
      chk("rst_payload", {alu_v1, alu_v2}, 64'd0);
      chk("rst_rob_pc", {alu_pc, 3'b0, alu_rob_tag}, 64'd0);
      rst_n = 1'b1;

      // Ready dispatch: issues on the edge after the dispatch edge
      disp(1, 0, 0, 3, 0, 0, 4, 7);
      @(negedge clk); idle();
      chk("lat_not_yet", 64'(alu_valid), 64'd0);
      chk("lat_count", 64'(rs_count), 64'd1);
      @(negedge clk);
      chk("lat_valid", 64'(alu_valid), 64'd1);
      chk("lat_rob", 64'(alu_rob_tag), 64'd7);
      chk("lat_v1v2", {alu_v1, alu_v2}, {32'd3, 32'd4});
      @(negedge clk);
      chk("lat_idle", 64'(alu_valid), 64'd0);

      // Two-channel wakeup, older entry first
      disp(2, 1, 2, 0, 0, 0, 10, 1);
      @(negedge clk);
      disp(2, 1, 3, 0, 0, 0, 10, 2);
      @(negedge clk); idle();
      cdb(0, 3, 'h55); cdb(1, 2, 'h66);
      @(negedge clk); idle();
      chk("wake_not_yet", 64'(alu_valid), 64'd0);
      @(negedge clk);
      chk("wake_a", {27'd0, alu_rob_tag, alu_v1}, {27'd0, 5'd1, 32'h66});
      @(negedge clk);
      chk("wake_b", {27'd0, alu_rob_tag, alu_v1}, {27'd0, 5'd2, 32'h55});
      @(negedge clk);

      // Dispatch-cycle bypass on operand 2
      cdb(1, 9, 'hABCD);
      disp(3, 0, 0, 1, 1, 9, 0, 4);
      @(negedge clk); idle();
      @(negedge clk);
      chk("byp_valid", 64'(alu_valid), 64'd1);
      chk("byp_v2", {27'd0, alu_rob_tag, alu_v2}, {27'd0, 5'd4, 32'hABCD});

      // Duplicate tags on both channels: channel 0 wins
      disp(4, 1, 5, 0, 0, 0, 2, 5);
      @(negedge clk); idle();
      cdb(0, 5, 'h11); cdb(1, 5, 'h22);
      @(negedge clk); idle();
      @(negedge clk);
      chk("dup_ch0", {27'd0, alu_rob_tag, alu_v1}, {27'd0, 5'd5, 32'h11});
      @(negedge clk);

      // Fill, drop while full, drain oldest-first
      alu_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         disp(5, 0, 0, 100 + i, 0, 0, i, i);
         @(negedge clk);
      end
      idle();
      chk("fill_full", 64'(rs_full), 64'd1);
      chk("fill_count", 64'(rs_count), 64'd16);
      chk("fill_head", 64'(alu_rob_tag), 64'd0);
      disp(5, 0, 0, 999, 0, 0, 0, 31);
      @(negedge clk); idle();
      chk("drop_count", 64'(rs_count), 64'd16);
      chk("drop_hold", {27'd0, alu_rob_tag, alu_v1}, {27'd0, 5'd0, 32'd100});
      alu_ready = 1'b1;
      disp(5, 0, 0, 998, 0, 0, 0, 30);
      @(negedge clk); idle();
      chk("drain_first", {27'd0, alu_rob_tag, 27'd0, rs_count}, {27'd0, 5'd1, 27'd0, 5'd15});
      for (int k = 2; k <= DEPTH; k++) begin
         @(negedge clk);
         chk("drain_step", {27'd0, alu_rob_tag, 27'd0, rs_count}, {27'd0, 5'(k), 27'd0, 5'(DEPTH - k)});
      end
      @(negedge clk);
      chk("drain_done", 64'(alu_valid), 64'd0);

      // Flush against dispatch, wakeup and pending issue; first with rdy low
      alu_ready = 1'b0;
      disp(6, 0, 0, 1, 0, 0, 1, 10);
      @(negedge clk);
      disp(6, 0, 0, 1, 0, 0, 1, 11);
      @(negedge clk);
      disp(6, 1, 6, 0, 0, 0, 1, 12);
      @(negedge clk); idle();
      chk("fl_pre", {alu_valid, 27'd0, rs_count, 27'd0, alu_rob_tag}, {1'b1, 27'd0, 5'd2, 27'd0, 5'd10});
      rdy = 1'b0;
      flush = 1'b1;
      disp(6, 0, 0, 7, 0, 0, 7, 13);
      cdb(0, 6, 'h77);
      alu_ready = 1'b1;
      @(negedge clk);
      chk("fl_hold", {alu_valid, 27'd0, rs_count, 27'd0, alu_rob_tag}, {1'b1, 27'd0, 5'd2, 27'd0, 5'd10});
      rdy = 1'b1;
      @(negedge clk); idle();
      chk("fl_clear", {alu_valid, 27'd0, rs_count}, 33'd0);
      @(negedge clk);
      chk("fl_after", {alu_valid, 27'd0, rs_count}, 33'd0);

      // Asynchronous reset with five entries held
      alu_ready = 1'b0;
      disp(7, 0, 0, 1, 0, 0, 1, 20);
      @(negedge clk);
      for (int i = 21; i <= 25; i++) begin
         disp(7, 1, 27, 0, 0, 0, 1, i);
         @(negedge clk);
      end
      idle();
      @(negedge clk);
      chk("ar_pre", {alu_valid, 27'd0, rs_count}, {1'b1, 27'd0, 5'd5});
      #2 rst_n = 1'b0;
      #1;
      chk("ar_count", 64'(rs_count), 64'd0);
      chk("ar_alu_valid", 64'(alu_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      alu_ready = 1'b1;
      @(negedge clk);
      chk("ar_after", {alu_valid, 27'd0, rs_count}, 33'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
